// File: rtl/div_unit_pkg.sv
//==============================================================================
// Module      : div_unit_pkg
// Description : Shared encodings and constants for the multi-cycle RV32M
//               divide/remainder unit: operation codes, sequencer state
//               encoding, default operand width and the INT_MIN / ALL_ONES
//               operand patterns used for special-case detection.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package div_unit_pkg;

    localparam int DEFAULT_N = 32;

    // Operation encodings (op input)
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    // Sequencer state encoding
    localparam int ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] ST_SPECIAL = 3'd1;
    localparam logic [ST_W-1:0] ST_CALC    = 3'd2;
    localparam logic [ST_W-1:0] ST_FIX     = 3'd3;
    localparam logic [ST_W-1:0] ST_DONE    = 3'd4;

    // Operand patterns at the default width
    localparam logic [DEFAULT_N-1:0] INT_MIN  = {1'b1, {(DEFAULT_N-1){1'b0}}};
    localparam logic [DEFAULT_N-1:0] ALL_ONES = {DEFAULT_N{1'b1}};

endpackage

`default_nettype wire

// File: rtl/div_step.sv
//==============================================================================
// Module      : div_step
// Description : One combinational radix-2 restoring division iteration.
//               {rem, quo} is shifted left by one, the divisor is trial-
//               subtracted from the partial remainder and the subtraction is
//               kept (quotient bit 1) or discarded (quotient bit 0).
// Ports       : rem_in  [N:0]   partial remainder before the step
//               quo_in  [N-1:0] partial quotient / remaining dividend bits
//               divisor [N-1:0] divisor magnitude
//               rem_out [N:0]   partial remainder after the step
//               quo_out [N-1:0] partial quotient after the step
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module div_step
    import div_unit_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic [N:0]   rem_in,
    input  logic [N-1:0] quo_in,
    input  logic [N-1:0] divisor,
    output logic [N:0]   rem_out,
    output logic [N-1:0] quo_out
);

    logic [N+1:0] w_rem_sh;
    logic [N+1:0] w_trial;

    // The partial remainder is always below the divisor, so the shifted value
    // fits in N+1 bits and bit N+1 of the difference is a reliable sign bit.
    assign w_rem_sh = {rem_in, quo_in[N-1]};
    assign w_trial  = w_rem_sh - {2'b00, divisor};

    always_comb begin
        rem_out = w_rem_sh[N:0];
        quo_out = {quo_in[N-2:0], 1'b0};
        if (!w_trial[N+1]) begin
            rem_out = w_trial[N:0];
            quo_out = {quo_in[N-2:0], 1'b1};
        end
    end

endmodule

`default_nettype wire

// File: rtl/div_unit.sv
//==============================================================================
// Module      : div_unit
// Description : Multi-cycle RV32M DIV/DIVU/REM/REMU unit, radix-2 restoring,
//               one quotient bit per cycle. Divide-by-zero and signed
//               overflow are resolved in a single SPECIAL cycle.
// Ports       : clk, rst (async, active high)
//               start       request pulse, honoured in IDLE and DONE
//               op[1:0]     00 DIV, 01 DIVU, 10 REM, 11 REMU
//               i0, i1      dividend, divisor
//               busy        high in SPECIAL / CALC / FIX
//               done        one-cycle completion pulse
//               result      quotient or remainder, held until next load
//               div_by_zero, overflow, zero  flags held with result
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module div_unit
    import div_unit_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] i0,
    input  logic [N-1:0] i1,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         div_by_zero,
    output logic         overflow,
    output logic         zero
);

    localparam int            CNT_W      = $clog2(N);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(N - 1);
    localparam logic [N-1:0]  C_INT_MIN  = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]  C_ALL_ONES = {N{1'b1}};

    logic [ST_W-1:0]  r_state;
    logic [ST_W-1:0]  w_state_nx;

    logic [N:0]       r_rem;
    logic [N-1:0]     r_quo;
    logic [N-1:0]     r_dvsr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_rem;
    logic             r_neg;
    logic             r_dz;
    logic             r_ov;

    logic             w_accept;
    logic             w_calc;
    logic             w_load_special;
    logic             w_load_fix;

    logic             w_signed;
    logic             w_sa;
    logic             w_sb;
    logic [N-1:0]     w_abs_a;
    logic [N-1:0]     w_abs_b;
    logic             w_dz;
    logic             w_ov;
    logic             w_special;
    logic [N-1:0]     w_spec_val;
    logic [N:0]       w_rem_nx;
    logic [N-1:0]     w_quo_nx;
    logic [N-1:0]     w_fixed;

    //--------------------------------------------------------------------------
    // Acceptance-time decode
    //--------------------------------------------------------------------------
    assign w_signed  = ~op[0];
    assign w_sa      = w_signed & i0[N-1];
    assign w_sb      = w_signed & i1[N-1];
    assign w_abs_a   = w_sa ? (-i0) : i0;
    assign w_abs_b   = w_sb ? (-i1) : i1;
    assign w_dz      = (i1 == '0);
    assign w_ov      = w_signed && (i0 == C_INT_MIN) && (i1 == C_ALL_ONES);
    assign w_special = w_dz | w_ov;

    // Divide-by-zero wins over overflow when both apply.
    always_comb begin
        if (w_dz) begin
            w_spec_val = op[1] ? i0 : C_ALL_ONES;
        end else begin
            w_spec_val = op[1] ? '0 : C_INT_MIN;
        end
    end

    //--------------------------------------------------------------------------
    // Sign correction: 0 negated is still 0, so no negative zero can appear.
    //--------------------------------------------------------------------------
    always_comb begin
        if (r_is_rem) begin
            w_fixed = r_neg ? (-r_rem[N-1:0]) : r_rem[N-1:0];
        end else begin
            w_fixed = r_neg ? (-r_quo) : r_quo;
        end
    end

    div_step #(.N(N)) u_step (
        .rem_in  (r_rem),
        .quo_in  (r_quo),
        .divisor (r_dvsr),
        .rem_out (w_rem_nx),
        .quo_out (w_quo_nx)
    );

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: next state
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nx = w_special ? ST_SPECIAL : ST_CALC;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_SPECIAL: w_state_nx = ST_DONE;
            ST_CALC:    w_state_nx = (r_cnt == C_CNT_LAST) ? ST_FIX : ST_CALC;
            ST_FIX:     w_state_nx = ST_DONE;
            default:    w_state_nx = ST_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // FSM: outputs and datapath enables
    //--------------------------------------------------------------------------
    always_comb begin
        busy           = 1'b0;
        done           = 1'b0;
        w_accept       = 1'b0;
        w_calc         = 1'b0;
        w_load_special = 1'b0;
        w_load_fix     = 1'b0;
        case (r_state)
            ST_IDLE:    w_accept = start;
            ST_SPECIAL: begin
                busy           = 1'b1;
                w_load_special = 1'b1;
            end
            ST_CALC: begin
                busy   = 1'b1;
                w_calc = 1'b1;
            end
            ST_FIX: begin
                busy       = 1'b1;
                w_load_fix = 1'b1;
            end
            ST_DONE: begin
                done     = 1'b1;
                w_accept = start;
            end
            default: ;
        endcase
    end

    //--------------------------------------------------------------------------
    // Datapath. In the special case r_quo carries the precomputed result.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvsr      <= '0;
            r_cnt       <= '0;
            r_is_rem    <= 1'b0;
            r_neg       <= 1'b0;
            r_dz        <= 1'b0;
            r_ov        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            zero        <= 1'b1;
        end else begin
            if (w_accept) begin
                r_is_rem <= op[1];
                r_neg    <= op[1] ? w_sa : (w_sa ^ w_sb);
                r_dz     <= w_dz;
                r_ov     <= w_ov & ~w_dz;
                r_rem    <= '0;
                r_quo    <= w_special ? w_spec_val : w_abs_a;
                r_dvsr   <= w_abs_b;
                r_cnt    <= '0;
            end else if (w_calc) begin
                r_rem <= w_rem_nx;
                r_quo <= w_quo_nx;
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_load_special) begin
                result      <= r_quo;
                div_by_zero <= r_dz;
                overflow    <= r_ov;
                zero        <= (r_quo == '0);
            end else if (w_load_fix) begin
                result      <= w_fixed;
                div_by_zero <= 1'b0;
                overflow    <= 1'b0;
                zero        <= (w_fixed == '0);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
//==============================================================================
// Module      : tb_div_unit
// Description : Directed self-checking bench for div_unit with hand-computed
//               expected quotients, remainders, flags and latencies.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_div_unit;
    import div_unit_pkg::*;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] i0;
    logic [N-1:0] i1;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         div_by_zero;
    logic         overflow;
    logic         zero;

    int           n_vec = 0;
    int           n_err = 0;
    logic [N-1:0] last_res;

    always #5 clk = ~clk;

    div_unit #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .i0          (i0),
        .i1          (i1),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .zero        (zero)
    );

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Returns the cycle number (start-sampling edge = cycle 0) in which done
    // is seen; gives up after a bounded number of cycles.
    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (lat < 200) begin
            @(negedge clk);
            if (done) return;
            lat++;
        end
    endtask

    // Must be entered at a negedge; leaves at the negedge of the done cycle.
    task automatic run(input string tag, input logic [1:0] o,
                       input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] res, input int exp_lat,
                       input logic dz, input logic ov);
        int lat;
        op    = o;
        i0    = a;
        i1    = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, " held"}, result, last_res);
        check({tag, " busy"}, N'(busy), N'(1));
        // Scramble the inputs; the operation was latched at acceptance.
        i0 = ~a;
        i1 = b ^ 32'h5;
        op = ~o;
        wait_done(1, lat);
        check({tag, " latency"}, N'(lat), N'(exp_lat));
        check({tag, " result"}, result, res);
        check({tag, " dz"}, N'(div_by_zero), N'(dz));
        check({tag, " ov"}, N'(overflow), N'(ov));
        check({tag, " zero"}, N'(zero), N'(res == '0));
        last_res = res;
    endtask

    initial begin
        int lat;
        int nd;
        rst      = 1'b1;
        start    = 1'b0;
        op       = 2'b00;
        i0       = '0;
        i1       = '0;
        last_res = '0;

        repeat (3) @(negedge clk);
        check("rst busy", N'(busy), N'(0));
        check("rst done", N'(done), N'(0));
        check("rst result", result, 32'h0);
        check("rst zero", N'(zero), N'(1));
        check("rst dz", N'(div_by_zero), N'(0));
        check("rst ov", N'(overflow), N'(0));
        rst = 1'b0;
        @(negedge clk);

        // Normal divides; each issues on the previous done cycle.
        run("divu_100_7",  OP_DIVU, 32'd100,        32'd7,          32'd14,         34, 1'b0, 1'b0);
        run("remu_100_7",  OP_REMU, 32'd100,        32'd7,          32'd2,          34, 1'b0, 1'b0);
        run("div_m7_2",    OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34, 1'b0, 1'b0);
        run("rem_m7_2",    OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34, 1'b0, 1'b0);
        run("div_7_m2",    OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34, 1'b0, 1'b0);
        run("rem_7_m2",    OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          34, 1'b0, 1'b0);
        run("div_0_m5",    OP_DIV,  32'd0,          32'hFFFF_FFFB,  32'd0,          34, 1'b0, 1'b0);

        // Divide by zero
        run("divu_5_0",    OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  2,  1'b1, 1'b0);
        run("rem_5_0",     OP_REM,  32'd5,          32'd0,          32'd5,          2,  1'b1, 1'b0);
        run("div_min_0",   OP_DIV,  32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  2,  1'b1, 1'b0);

        // Signed overflow
        run("div_ovf",     OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2,  1'b0, 1'b1);
        run("rem_ovf",     OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          2,  1'b0, 1'b1);
        run("divu_big",    OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34, 1'b0, 1'b0);
        run("divu_0_3",    OP_DIVU, 32'd0,          32'd3,          32'd0,          34, 1'b0, 1'b0);

        // Start during CALC is ignored, operand changes have no effect.
        op    = OP_DIVU;
        i0    = 32'd1000;
        i1    = 32'd10;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(negedge clk);
        op    = OP_REMU;
        i0    = 32'd55;
        i1    = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        i0    = 32'd1;
        i1    = 32'd1;
        wait_done(11, lat);
        check("ign latency", N'(lat), N'(34));
        check("ign result", result, 32'd100);
        check("ign zero", N'(zero), N'(0));
        last_res = 32'd100;

        // Asynchronous reset in the middle of CALC.
        op    = OP_DIVU;
        i0    = 32'd77;
        i1    = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (14) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst busy", N'(busy), N'(0));
        check("arst result", result, 32'd0);
        check("arst zero", N'(zero), N'(1));
        check("arst done", N'(done), N'(0));
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 2) rst = 1'b0;
            if (done) nd++;
        end
        check("arst no done", N'(nd), N'(0));
        last_res = '0;
        run("after_rst",   OP_DIVU, 32'd77,         32'd5,          32'd15,         34, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/div_unit.md
Name: div_unit

Overview:
Multi-cycle RV32M divide/remainder unit. It sits beside the single-cycle ALU in the execute stage and takes the same operand pair (i0 = dividend, i1 = divisor). The sequencer stalls the core while `busy` is high. It uses a radix-2 restoring algorithm (one quotient bit per cycle) and reports a zero/divide-by-zero/overflow flag set alongside the result.

Parameters:
- N, 32, operand/result width in bits (the sequence counter is sized to count N iterations).

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only when not busy.
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- i0  input  N  dividend.
- i1  input  N  divisor.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  single-cycle completion pulse.
- result  output  N  quotient (DIV/DIVU) or remainder (REM/REMU); held until the next accepted start.
- div_by_zero  output  1  divisor was zero; valid with done, held with result.
- overflow  output  1  signed DIV/REM of 0x80000000 by 0xFFFFFFFF; valid with done, held.
- zero  output  1  result == 0; held with result.

Behaviour:
- Reset (async, any state): state=IDLE. busy, done, result, div_by_zero, overflow = 0; zero = 1; any operation in flight is aborted with no done.
- States and transitions:
  - IDLE: on start, latch op, the operands and the flags, then go to SPECIAL or CALC.
  - SPECIAL: one cycle, then DONE.
  - CALC: N cycles, then FIX.
  - FIX: one cycle, then DONE.
  - DONE: one cycle, then IDLE; done=1 here.
- Acceptance: start is honoured in IDLE and in DONE (back-to-back issue). start is ignored in SPECIAL, CALC and FIX.
- Latency, counted from the clock edge that samples start:
  - Normal case: done is high in cycle N+2 (cycle 34 for N=32).
  - Special case: done is high in cycle 2.
- Special-case precedence:
  1. Divisor == 0 applies to all ops: quotient = all ones, remainder = i0, div_by_zero = 1.
  2. Signed overflow applies to DIV and REM only: quotient = 0x80000000, remainder = 0, overflow = 1.
  - div_by_zero takes priority when both conditions would apply.
- Signed ops: magnitudes are taken at acceptance.
  - Quotient negated when i0[N-1] ^ i1[N-1].
  - Remainder negated when i0[N-1].
  - The result of 0 / negative divisor is 0 (no negative zero).
- CALC iteration, where rem is (N+1) bits and quo is N bits:
  - Shift {rem, quo} left by one.
  - Trial = rem − |divisor|.
  - If the trial is non-negative, rem = trial and quo LSB = 1; otherwise restore.
  - A counter counts N iterations; exit when the counter reaches N−1.
- FIX applies the sign correction and loads result. zero is updated from the loaded result.
- Result and flags change only when a new result is loaded. Accepting a new start leaves result and flags unchanged until that operation's done.
- busy = 1 in SPECIAL, CALC and FIX; busy = 0 in IDLE and DONE.
- Operands are latched at acceptance: changes to i0, i1 and op while busy have no effect.

Decomposition:
- Shared package:
  - Op encodings (DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11).
  - State encoding (IDLE, SPECIAL, CALC, FIX, DONE).
  - Default N.
  - The constants INT_MIN = 1 followed by N−1 zeros, and ALL_ONES.
- Sub-module div_step: combinational single restoring iteration (rem_in, quo_in, divisor → rem_out, quo_out). It is instantiated once in div_unit and reused every CALC cycle.

Test Plan:
- DIVU 100/7, then REMU 100/7 issued on the DIVU done cycle:
  - DIVU: result=14, zero=0, flags 0, done in cycle 34.
  - REMU: result=2, done 34 cycles after its start.
- DIV −7/2 → 0xFFFFFFFD (−3); REM −7/2 → 0xFFFFFFFF (−1); DIV 7/−2 → −3; REM 7/−2 → 1.
- Divide by zero:
  - DIVU 5/0 → 0xFFFFFFFF, div_by_zero=1, done in cycle 2.
  - REM 5/0 → 5.
  - DIV 0x80000000/0 → div_by_zero=1, overflow=0.
- Signed overflow:
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000, overflow=1, done in cycle 2.
  - REM of the same operands → 0, zero=1.
  - DIVU of the same operands → 0 with overflow=0, in 34 cycles.
- Protocol:
  - start pulsed in cycle 10 of a CALC is ignored; the first result is unchanged.
  - Operand changes while busy do not alter the result.
  - DIVU 0/3 → result 0, zero=1.
- Reset asserted asynchronously in cycle 15 of CALC:
  - Immediately busy=0, result=0, zero=1, and no done pulse follows.
  - A start after reset is released completes normally.
